int_req_ctrl: RTL and testbench
===============================

Name: int_req_ctrl

Overview:
- Interrupt request controller directly upstream of the PC/interrupt sequencing stage.
- Synchronises external IRQ lines, detects rising edges, latches pending bits and applies a CPU-writable mask.
- Selects the highest-priority source and issues a one-cycle INT pulse plus a cause ID to the PC stage.
- Holds further dispatch until the PC stage's RFE (return-from-exception) is seen. No nesting.

Parameters:
- N_IRQ, 8, number of external interrupt lines (2..32).
- SYNC_STAGES, 2, synchroniser flops per line (>=2).
- CAUSE_W, clog2(N_IRQ), width of cause ID.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- irq  in  N_IRQ  external level lines, asynchronous to clk.
- mask_we  in  1  write strobe for the mask register.
- mask_wdata  in  N_IRQ  new mask; 1 = source enabled.
- pend_clr_we  in  1  strobe for software clear of pending bits.
- pend_clr  in  N_IRQ  1 = clear the corresponding pending bit.
- RFE  in  1  return-from-exception from the PC stage; one-cycle pulse.
- INT  out  1  registered; one-cycle interrupt request to the PC stage.
- int_cause  out  CAUSE_W  registered; ID of the dispatched source, held until the next dispatch.
- int_busy  out  1  registered; high from the INT cycle until RFE is accepted.
- mask  out  N_IRQ  current mask register.
- pending  out  N_IRQ  current pending register.

Behaviour:
- Reset (reset=0, asynchronous):
  - INT=0, int_cause=0, int_busy=0, mask=0 (all sources disabled), pending=0.
  - All synchroniser and edge-history flops 0; state=IDLE.
  - Reset mid-service discards pending and in-service state; no INT is issued during reset or on the first cycle after it.
- Per line:
  - SYNC_STAGES flop synchroniser, then rising-edge detect: edge = sync_last & ~sync_prev.
  - An edge sets the pending bit. Edges are detected regardless of mask; masking only gates dispatch.
- Pending update priority, per bit, per cycle:
  - set-by-edge beats dispatch-clear, and dispatch-clear beats software clear.
  - A bit with a simultaneous edge and clear ends the cycle as 1.
- Mask: mask_we loads mask_wdata at the clock edge. Dispatch in the same cycle uses the old (registered) mask.
- Eligible = pending & mask. Priority is fixed: lowest index wins.
- State machine (IDLE, REQ, SERVICE):
  - IDLE: if eligible != 0, go to REQ. At that edge: INT<=1, int_busy<=1, int_cause<=winner index, pending[winner]<=0 (subject to the set-wins rule). Otherwise stay.
  - REQ: exactly one cycle. INT<=0, go to SERVICE.
  - SERVICE: INT=0, int_busy=1. New edges keep accumulating in pending. On RFE=1: int_busy<=0, go to IDLE.
- RFE handling:
  - RFE is ignored in IDLE and REQ.
  - An RFE that coincides with the REQ cycle is dropped; the PC stage must not issue it there.
- Latency:
  - irq first sampled high at edge E0 while IDLE and unmasked: pending set at E0+SYNC_STAGES, INT high after edge E0+SYNC_STAGES+1.
  - With SYNC_STAGES=2, INT is high in the cycle following the 3rd edge after E0.
- Back-to-back: with RFE accepted at edge K and another source eligible, IDLE is entered after K and INT rises after edge K+1. This gives a minimum INT spacing of 3 cycles from RFE.
- A level held high produces one edge, so one dispatch. It re-arms only after irq returns low for at least one synchronised sample.
- int_cause is not cleared by RFE; it holds the last dispatched ID.

Decomposition:
- Shared package/header holds:
  - state encoding IDLE=2'd0, REQ=2'd1, SERVICE=2'd2;
  - N_IRQ default;
  - CAUSE_W derivation;
  - a priority-encoder function returning the lowest set index.
- One sub-module, irq_sync_edge: SYNC_STAGES synchroniser plus rising-edge detect for one line. It is instantiated N_IRQ times via generate.
- Top level holds the pending register, the mask register and the FSM.

Test Plan:
- Reset, then mask_wdata=8'h04. Raise irq[2] at E0 -> INT pulses for exactly one cycle after edge E0+3, int_cause=2, int_busy=1, pending=0.
- Raise irq[5] and irq[1] in the same cycle with mask=8'hFF -> first INT with cause=1. Pulse RFE -> INT with cause=5 exactly 2 edges later. pending=0 after the second dispatch.
- mask=8'h00, edge on irq[3] -> pending=8'h08 and no INT. Then write mask=8'h08 -> INT with cause=3 one edge after the mask write.
- During SERVICE for cause 0, edge on irq[0] again -> pending[0]=1, no INT until RFE, then INT with cause=0.
- Edge on irq[4] coincides with pend_clr_we=1, pend_clr=8'h10 -> pending[4]=1 (set wins).
- Assert reset while int_busy=1 with pending=8'h22 -> all outputs 0 immediately. After release, no INT without a new edge, even if irq lines are still high.

Source files
------------

// File: rtl/int_req_ctrl_pkg.sv
// Shared definitions for the interrupt request controller.
//   state_e      : dispatch FSM encoding
//   N_IRQ_DEF    : default number of external interrupt lines
//   cause_width  : width of the cause ID for a given line count
//   lowest_set   : fixed-priority encoder, lowest set index wins
package int_req_ctrl_pkg;

    localparam int N_IRQ_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } state_e;

    // A single line still needs a 1-bit cause field.
    function automatic int cause_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Scans downward so the last hit is the lowest index.
    function automatic logic [4:0] lowest_set(input logic [31:0] vec);
        logic [4:0] idx;
        idx = '0;
        for (int i = 31; i >= 0; i--) begin
            if (vec[i]) idx = 5'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/int_req_ctrl_sync.sv
// One external IRQ line: SYNC_STAGES-deep synchroniser followed by a
// rising-edge detector.
//   clk      : system clock
//   reset    : asynchronous active-low reset
//   irq_in   : raw line, asynchronous to clk
//   edge_out : one-cycle pulse on a synchronised 0->1 transition
module irq_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic irq_in,
    output logic edge_out
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q, prev_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], irq_in};
        prev_d = sync_q[SYNC_STAGES-1];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign edge_out = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/int_req_ctrl.sv
// Interrupt request controller feeding the PC/interrupt sequencing stage.
// Latches synchronised rising edges into a pending register, gates them with
// a CPU-writable mask and dispatches the lowest-index eligible source as a
// one-cycle INT plus cause ID. No further dispatch until RFE is seen.
//   clk, reset              : clock, asynchronous active-low reset
//   irq                     : external level lines
//   mask_we / mask_wdata    : mask register write (1 = enabled)
//   pend_clr_we / pend_clr  : software clear of pending bits
//   RFE                     : return-from-exception pulse
//   INT, int_cause, int_busy: dispatch outputs (registered)
//   mask, pending           : current register contents
//
// state      | meaning
// -----------+-------------------------------------------------
// ST_IDLE    | no source in service; dispatch when eligible != 0
// ST_REQ     | INT cycle, lasts exactly one clock; RFE ignored
// ST_SERVICE | waiting for RFE; new edges keep accumulating
module int_req_ctrl
    import int_req_ctrl_pkg::*;
#(
    parameter int N_IRQ       = N_IRQ_DEF,
    parameter int SYNC_STAGES = 2,
    parameter int CAUSE_W     = cause_width(N_IRQ)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N_IRQ-1:0]   irq,
    input  logic               mask_we,
    input  logic [N_IRQ-1:0]   mask_wdata,
    input  logic               pend_clr_we,
    input  logic [N_IRQ-1:0]   pend_clr,
    input  logic               RFE,
    output logic               INT,
    output logic [CAUSE_W-1:0] int_cause,
    output logic               int_busy,
    output logic [N_IRQ-1:0]   mask,
    output logic [N_IRQ-1:0]   pending
);

    logic [N_IRQ-1:0]   edge_det;
    logic [N_IRQ-1:0]   eligible;
    logic [N_IRQ-1:0]   disp_clr;
    logic [N_IRQ-1:0]   sw_clr;
    logic [4:0]         winner;

    state_e             state_q, state_d;
    logic               int_q, int_d;
    logic               busy_q, busy_d;
    logic [CAUSE_W-1:0] cause_q, cause_d;
    logic [N_IRQ-1:0]   mask_q, mask_d;
    logic [N_IRQ-1:0]   pending_q, pending_d;

    for (genvar g = 0; g < N_IRQ; g++) begin : g_line
        irq_sync_edge #(
            .SYNC_STAGES (SYNC_STAGES)
        ) u_sync (
            .clk      (clk),
            .reset    (reset),
            .irq_in   (irq[g]),
            .edge_out (edge_det[g])
        );
    end

    // Dispatch looks at the registered mask, so a same-cycle mask write
    // only takes effect from the next cycle.
    assign eligible = pending_q & mask_q;
    assign winner   = lowest_set(32'(eligible));
    assign sw_clr   = pend_clr_we ? pend_clr : '0;

    always_comb begin
        state_d  = state_q;
        int_d    = 1'b0;
        busy_d   = busy_q;
        cause_d  = cause_q;
        disp_clr = '0;
        case (state_q)
            ST_IDLE: begin
                if (|eligible) begin
                    state_d  = ST_REQ;
                    int_d    = 1'b1;
                    busy_d   = 1'b1;
                    cause_d  = CAUSE_W'(winner);
                    disp_clr = N_IRQ'(1) << winner;
                end
            end
            ST_REQ:     state_d = ST_SERVICE;
            ST_SERVICE: begin
                if (RFE) begin
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default:    state_d = ST_IDLE;
        endcase

        // Edge is OR-ed in last so a fresh edge survives any clear.
        pending_d = (pending_q & ~disp_clr & ~sw_clr) | edge_det;
        mask_d    = mask_we ? mask_wdata : mask_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            int_q     <= 1'b0;
            busy_q    <= 1'b0;
            cause_q   <= '0;
            mask_q    <= '0;
            pending_q <= '0;
        end else begin
            state_q   <= state_d;
            int_q     <= int_d;
            busy_q    <= busy_d;
            cause_q   <= cause_d;
            mask_q    <= mask_d;
            pending_q <= pending_d;
        end
    end

    assign INT       = int_q;
    assign int_cause = cause_q;
    assign int_busy  = busy_q;
    assign mask      = mask_q;
    assign pending   = pending_q;

endmodule

// File: tb/tb_int_req_ctrl.sv
module tb_int_req_ctrl;

    localparam int S = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] irq = '0;
    logic       mask_we = 1'b0;
    logic [7:0] mask_wdata = '0;
    logic       pend_clr_we = 1'b0;
    logic [7:0] pend_clr = '0;
    logic       RFE = 1'b0;
    logic       INT;
    logic [2:0] int_cause;
    logic       int_busy;
    logic [7:0] mask;
    logic [7:0] pending;

    int n_chk = 0;
    int n_fail = 0;

    int_req_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .irq         (irq),
        .mask_we     (mask_we),
        .mask_wdata  (mask_wdata),
        .pend_clr_we (pend_clr_we),
        .pend_clr    (pend_clr),
        .RFE         (RFE),
        .INT         (INT),
        .int_cause   (int_cause),
        .int_busy    (int_busy),
        .mask        (mask),
        .pending     (pending)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: irq sample history, pending/mask words and a
    // busy/int flag pair describing the dispatch handshake.
    logic [7:0] m_smp [0:S];
    logic [7:0] m_pend = '0;
    logic [7:0] m_mask = '0;
    logic       m_int = 1'b0;
    logic       m_busy = 1'b0;
    logic [2:0] m_cause = '0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i <= S; i++) m_smp[i] <= '0;
            m_pend  <= '0;
            m_mask  <= '0;
            m_int   <= 1'b0;
            m_busy  <= 1'b0;
            m_cause <= '0;
        end else begin
            logic [7:0] edges, elig, clr;
            int         win;
            bit         disp, nbusy;
            edges = m_smp[S-1] & ~m_smp[S];
            for (int i = S; i > 0; i--) m_smp[i] <= m_smp[i-1];
            m_smp[0] <= irq;
            elig = m_pend & m_mask;
            disp = !m_busy && (elig != 0);
            win = 0;
            for (int i = 7; i >= 0; i--) if (elig[i]) win = i;
            clr = pend_clr_we ? pend_clr : 8'h00;
            if (disp) clr[win] = 1'b1;
            nbusy = m_busy;
            if (m_busy && !m_int && RFE) nbusy = 1'b0;
            if (disp) nbusy = 1'b1;
            m_busy <= nbusy;
            m_pend <= (m_pend & ~clr) | edges;
            if (mask_we) m_mask <= mask_wdata;
            m_int <= disp;
            if (disp) m_cause <= 3'(win);
        end
    end

    always @(negedge clk) begin
        check("m_INT", 32'(INT), 32'(m_int));
        check("m_cause", 32'(int_cause), 32'(m_cause));
        check("m_busy", 32'(int_busy), 32'(m_busy));
        check("m_mask", 32'(mask), 32'(m_mask));
        check("m_pending", 32'(pending), 32'(m_pend));
    end

    task automatic write_mask(input logic [7:0] v);
        mask_we = 1'b1;
        mask_wdata = v;
        @(negedge clk);
        mask_we = 1'b0;
    endtask

    task automatic do_rfe();
        RFE = 1'b1;
        @(negedge clk);
        RFE = 1'b0;
    endtask

    task automatic wait_int(input int max_cyc, input string tag, output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (INT !== 1'b1 && cyc < max_cyc);
        check({tag, "_int_seen"}, 32'(INT), 32'd1);
    endtask

    initial begin
        int n;
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_INT", 32'(INT), 32'd0);
        check("rst_cause", 32'(int_cause), 32'd0);
        check("rst_busy", 32'(int_busy), 32'd0);
        check("rst_mask", 32'(mask), 32'd0);
        check("rst_pending", 32'(pending), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // single source latency and pulse width
        write_mask(8'h04);
        irq = 8'h04;
        wait_int(10, "t1", n);
        check("t1_latency", 32'(n), 32'd4);
        check("t1_cause", 32'(int_cause), 32'd2);
        check("t1_busy", 32'(int_busy), 32'd1);
        check("t1_pending", 32'(pending), 32'd0);
        @(negedge clk);
        check("t1_pulse_width", 32'(INT), 32'd0);
        irq = 8'h00;
        do_rfe();
        check("t1_busy_after_rfe", 32'(int_busy), 32'd0);

        // two simultaneous sources, back-to-back after RFE
        write_mask(8'hFF);
        irq = 8'h22;
        wait_int(10, "t2a", n);
        check("t2_first_cause", 32'(int_cause), 32'd1);
        @(negedge clk);
        do_rfe();
        check("t2_gap_INT", 32'(INT), 32'd0);
        check("t2_gap_busy", 32'(int_busy), 32'd0);
        @(negedge clk);
        check("t2_second_INT", 32'(INT), 32'd1);
        check("t2_second_cause", 32'(int_cause), 32'd5);
        check("t2_pending", 32'(pending), 32'd0);
        @(negedge clk);
        do_rfe();
        irq = 8'h00;

        // masked edge stays pending, dispatched after mask write
        write_mask(8'h00);
        irq = 8'h08;
        repeat (4) @(negedge clk);
        check("t3_pending", 32'(pending), 32'h08);
        check("t3_no_INT", 32'(INT), 32'd0);
        write_mask(8'h08);
        check("t3_INT_not_yet", 32'(INT), 32'd0);
        @(negedge clk);
        check("t3_INT", 32'(INT), 32'd1);
        check("t3_cause", 32'(int_cause), 32'd3);
        @(negedge clk);
        do_rfe();
        irq = 8'h00;

        // re-edge of the in-service source waits for RFE
        write_mask(8'h01);
        irq = 8'h01;
        wait_int(10, "t4a", n);
        check("t4_cause_a", 32'(int_cause), 32'd0);
        @(negedge clk);
        irq = 8'h00;
        repeat (2) @(negedge clk);
        irq = 8'h01;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t4_held_INT", 32'(INT), 32'd0);
        end
        check("t4_pending", 32'(pending), 32'h01);
        check("t4_busy", 32'(int_busy), 32'd1);
        do_rfe();
        @(negedge clk);
        check("t4_INT_after_rfe", 32'(INT), 32'd1);
        check("t4_cause_b", 32'(int_cause), 32'd0);
        @(negedge clk);
        do_rfe();
        irq = 8'h00;

        // edge and software clear in the same cycle: set wins
        write_mask(8'h00);
        irq = 8'h10;
        repeat (2) @(negedge clk);
        pend_clr_we = 1'b1;
        pend_clr = 8'h10;
        @(negedge clk);
        pend_clr_we = 1'b0;
        check("t5_set_wins", 32'(pending), 32'h10);
        pend_clr_we = 1'b1;
        @(negedge clk);
        pend_clr_we = 1'b0;
        check("t5_sw_clear", 32'(pending), 32'h00);
        irq = 8'h00;

        // asynchronous reset during service
        write_mask(8'hFF);
        irq = 8'h01;
        wait_int(10, "t6", n);
        @(negedge clk);
        irq = 8'h23;
        repeat (4) @(negedge clk);
        check("t6_pre_pending", 32'(pending), 32'h22);
        check("t6_pre_busy", 32'(int_busy), 32'd1);
        #2 reset = 1'b0;
        #1;
        check("t6_rst_INT", 32'(INT), 32'd0);
        check("t6_rst_busy", 32'(int_busy), 32'd0);
        check("t6_rst_cause", 32'(int_cause), 32'd0);
        check("t6_rst_mask", 32'(mask), 32'd0);
        check("t6_rst_pending", 32'(pending), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("t6_post_no_INT", 32'(INT), 32'd0);
        end
        irq = 8'h00;
        pend_clr_we = 1'b1;
        pend_clr = 8'hFF;
        @(negedge clk);
        pend_clr_we = 1'b0;

        // randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            logic [7:0] flip;
            flip = '0;
            for (int b = 0; b < 8; b++) flip[b] = ($urandom_range(0, 7) == 0);
            irq = irq ^ flip;
            mask_we = ($urandom_range(0, 15) == 0);
            mask_wdata = 8'($urandom);
            pend_clr_we = ($urandom_range(0, 9) == 0);
            pend_clr = 8'($urandom);
            RFE = ($urandom_range(0, 3) == 0);
            @(negedge clk);
        end
        mask_we = 1'b0;
        pend_clr_we = 1'b0;
        RFE = 1'b0;
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
